// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer
//   Serial-to-parallel receiver for an on-chip UART link. Recovers one frame
//   (start 0, DATA_BITS data MSB-first, parity, stop 1), checks parity and stop,
//   and presents the raw frame, payload and error flags on a valid/ready output.
//   The serial line shares this clock domain, so there is no synchronizer.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   data_rx     serial line, idle high
//   out_ready   consumer ready
//   out_valid   frame_out/data_out/parity_err/frame_err valid
//   frame_out   raw frame, bit FRAME_W-1 = start ... bit 0 = stop
//   data_out    payload = frame_out[FRAME_W-2:2]
//   parity_err  received parity differs from the computed parity
//   frame_err   stop bit sampled 0
//   overrun     one-cycle pulse when a completed frame is dropped
//   busy        receiver is inside a frame (not IDLE, not WAIT_HI)
//
// Handshake: a frame transfers on every clock edge where out_valid && out_ready.
//   While out_valid && !out_ready, every output except overrun/busy is held
//   stable. out_ready has no effect while out_valid is low.
module uart_rx_deframer #(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_BITS    = 5,
  parameter int PARITY_ODD   = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   data_rx,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [DATA_BITS+2:0]   frame_out,
  output logic [DATA_BITS-1:0]   data_out,
  output logic                   parity_err,
  output logic                   frame_err,
  output logic                   overrun,
  output logic                   busy
);

  localparam int FRAME_W  = DATA_BITS + 3;
  localparam int BAUD_W   = $clog2(CLKS_PER_BIT) + 1;
  localparam int BIT_W    = $clog2(DATA_BITS) + 1;
  localparam int HALF_INT = (CLKS_PER_BIT - 1) / 2;

  localparam logic [BAUD_W-1:0] BAUD_FULL = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(HALF_INT);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
  localparam logic              PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_WAIT_HI = 3'd0,
    S_IDLE    = 3'd1,
    S_START   = 3'd2,
    S_DATA    = 3'd3,
    S_PARITY  = 3'd4,
    S_STOP    = 3'd5
  } state_t;

  state_t                r_state;
  logic [BAUD_W-1:0]     r_baud;
  logic [BIT_W-1:0]      r_bit;
  // Holds start, data and parity bits; the stop bit is taken live from data_rx.
  logic [FRAME_W-2:0]    r_shift;
  logic                  r_valid;
  logic [FRAME_W-1:0]    r_frame;
  logic                  r_perr;
  logic                  r_ferr;
  logic                  r_overrun;

  state_t                w_state_nxt;
  logic [BAUD_W-1:0]     w_baud_nxt;
  logic [BIT_W-1:0]      w_bit_nxt;
  logic [FRAME_W-2:0]    w_shift_nxt;
  logic                  w_done;
  logic                  w_baud_zero;
  logic [FRAME_W-2:0]    w_shift_in;
  logic                  w_par_calc;
  logic                  w_can_load;

  assign w_baud_zero = (r_baud == '0);
  assign w_shift_in  = {r_shift[FRAME_W-3:0], data_rx};
  assign w_par_calc  = (^r_shift[FRAME_W-3:1]) ^ PAR_ODD;
  assign w_can_load  = !r_valid || out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_done      = 1'b0;
    case (r_state)
      S_WAIT_HI: begin
        if (data_rx) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (!data_rx) begin
          // With no half-bit wait the detect edge doubles as the start sample.
          if (HALF_INT == 0) begin
            w_state_nxt = S_DATA;
            w_baud_nxt  = BAUD_FULL;
            w_bit_nxt   = '0;
            w_shift_nxt = w_shift_in;
          end else begin
            w_state_nxt = S_START;
            w_baud_nxt  = BAUD_HALF;
          end
        end
      end
      S_START: begin
        if (!w_baud_zero) begin
          w_baud_nxt = r_baud - BAUD_ONE;
        end else if (data_rx) begin
          w_state_nxt = S_IDLE;  // low pulse shorter than half a bit
        end else begin
          w_state_nxt = S_DATA;
          w_baud_nxt  = BAUD_FULL;
          w_bit_nxt   = '0;
          w_shift_nxt = w_shift_in;
        end
      end
      S_DATA: begin
        if (!w_baud_zero) begin
          w_baud_nxt = r_baud - BAUD_ONE;
        end else begin
          w_shift_nxt = w_shift_in;
          w_baud_nxt  = BAUD_FULL;
          if (r_bit == BIT_LAST) w_state_nxt = S_PARITY;
          else                   w_bit_nxt   = r_bit + BIT_ONE;
        end
      end
      S_PARITY: begin
        if (!w_baud_zero) begin
          w_baud_nxt = r_baud - BAUD_ONE;
        end else begin
          w_shift_nxt = w_shift_in;
          w_baud_nxt  = BAUD_FULL;
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (!w_baud_zero) begin
          w_baud_nxt = r_baud - BAUD_ONE;
        end else begin
          w_done = 1'b1;
          // A low stop bit may be a break; wait for the line to go high again.
          w_state_nxt = data_rx ? S_IDLE : S_WAIT_HI;
        end
      end
      default: w_state_nxt = S_WAIT_HI;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_WAIT_HI;
      r_baud    <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_valid   <= 1'b0;
      r_frame   <= '0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_bit     <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_overrun <= 1'b0;
      if (w_done && w_can_load) begin
        r_frame <= {r_shift, data_rx};
        r_perr  <= r_shift[0] ^ w_par_calc;
        r_ferr  <= ~data_rx;
        r_valid <= 1'b1;
      end else if (w_done) begin
        r_overrun <= 1'b1;  // held frame untouched, new one dropped
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_valid;
  assign frame_out  = r_frame;
  assign data_out   = r_frame[FRAME_W-2:2];
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign overrun    = r_overrun;
  assign busy       = (r_state != S_IDLE) && (r_state != S_WAIT_HI);

endmodule

// File: tb/tb_uart_rx_deframer.sv
module tb_uart_rx_deframer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       rx1, rdy1, vld1, pe1, fe1, ovr1, bsy1;
  logic [7:0] frm1;
  logic [4:0] dat1;
  logic       rx4, rdy4, vld4, pe4, fe4, ovr4, bsy4;
  logic [7:0] frm4;
  logic [4:0] dat4;

  uart_rx_deframer #(.CLKS_PER_BIT(1), .DATA_BITS(5), .PARITY_ODD(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .data_rx(rx1), .out_ready(rdy1),
    .out_valid(vld1), .frame_out(frm1), .data_out(dat1),
    .parity_err(pe1), .frame_err(fe1), .overrun(ovr1), .busy(bsy1)
  );

  uart_rx_deframer #(.CLKS_PER_BIT(4), .DATA_BITS(5), .PARITY_ODD(0)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .data_rx(rx4), .out_ready(rdy4),
    .out_valid(vld4), .frame_out(frm4), .data_out(dat4),
    .parity_err(pe4), .frame_err(fe4), .overrun(ovr4), .busy(bsy4)
  );

  // ---------------- scoreboard ----------------
  // item = {frame[7:0], parity_err, frame_err}
  logic [9:0] exp_q1[$];
  logic [9:0] exp_q4[$];
  int n_total = 0;
  int n_bad   = 0;
  int ovr_cnt1 = 0;
  int ovr_cnt4 = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: even parity over the payload, stop must be 1.
  function automatic logic [9:0] model_item(input logic [7:0] f);
    logic [4:0] d;
    logic       perr;
    d    = f[6:2];
    perr = f[1] ^ (^d);
    return {f, perr, ~f[0]};
  endfunction

  task automatic pop_compare1();
    logic [9:0] it;
    if (exp_q1.size() == 0) begin
      check_val("unexpected_frame1", {24'd0, frm1}, 32'hFFFF_FFFF);
    end else begin
      it = exp_q1.pop_front();
      check_val("frame1", {24'd0, frm1}, {24'd0, it[9:2]});
      check_val("data1",  {27'd0, dat1}, {27'd0, it[8:4]});
      check_val("perr1",  {31'd0, pe1},  {31'd0, it[1]});
      check_val("ferr1",  {31'd0, fe1},  {31'd0, it[0]});
    end
  endtask

  task automatic pop_compare4();
    logic [9:0] it;
    if (exp_q4.size() == 0) begin
      check_val("unexpected_frame4", {24'd0, frm4}, 32'hFFFF_FFFF);
    end else begin
      it = exp_q4.pop_front();
      check_val("frame4", {24'd0, frm4}, {24'd0, it[9:2]});
      check_val("data4",  {27'd0, dat4}, {27'd0, it[8:4]});
      check_val("perr4",  {31'd0, pe4},  {31'd0, it[1]});
      check_val("ferr4",  {31'd0, fe4},  {31'd0, it[0]});
    end
  endtask

  // Monitors sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && vld1 && rdy1) pop_compare1();
    if (rst_n && vld4 && rdy4) pop_compare4();
    if (ovr1) ovr_cnt1++;
    if (ovr4) ovr_cnt4++;
  end

  // ---------------- drivers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One bit per clock, MSB (start) first. Returns 1 ns after the stop-sample edge.
  task automatic send1(input logic [7:0] f, input bit expect_it);
    if (expect_it) exp_q1.push_back(model_item(f));
    for (int i = 7; i >= 0; i--) begin
      rx1 = f[i];
      tick(1);
    end
  endtask

  task automatic send4(input logic [7:0] f, input bit expect_it);
    if (expect_it) exp_q4.push_back(model_item(f));
    for (int i = 7; i >= 0; i--) begin
      rx4 = f[i];
      tick(4);
    end
  endtask

  task automatic check_all_zero1(input string tag);
    check_val({tag, "_vld"}, {31'd0, vld1}, 32'd0);
    check_val({tag, "_frm"}, {24'd0, frm1}, 32'd0);
    check_val({tag, "_dat"}, {27'd0, dat1}, 32'd0);
    check_val({tag, "_err"}, {30'd0, pe1, fe1}, 32'd0);
    check_val({tag, "_ovr"}, {31'd0, ovr1}, 32'd0);
    check_val({tag, "_bsy"}, {31'd0, bsy1}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int ovr_base;
  int seed_gap;

  initial begin
    rx1 = 1'b1; rx4 = 1'b1; rdy1 = 1'b1; rdy4 = 1'b1;
    rst_n = 1'b0;
    tick(3);
    check_all_zero1("rst1");
    check_val("rst4_vld", {31'd0, vld4}, 32'd0);
    check_val("rst4_bsy", {31'd0, bsy4}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // T1: clean frame, valid exactly at the stop-sample edge, one cycle wide
    send1(8'h5B, 1'b1);
    check_val("t1_valid_at_k7", {31'd0, vld1}, 32'd1);
    check_val("t1_frame_now", {24'd0, frm1}, 32'h5B);
    tick(1);
    check_val("t1_valid_pulse", {31'd0, vld1}, 32'd0);

    // T2: parity error
    send1(8'h59, 1'b1);
    tick(1);

    // Random payloads with correct parity/stop, random idle gaps (incl. back-to-back)
    for (int n = 0; n < 6; n++) begin
      logic [4:0] d;
      d = 5'($urandom_range(0, 31));
      send1({1'b0, d, ^d, 1'b1}, 1'b1);
      seed_gap = $urandom_range(0, 2);
      if (seed_gap != 0) tick(seed_gap);
    end
    tick(1);

    // T3: stop bit low, line held low -> must wait for line high
    send1(8'h5A, 1'b1);
    rx1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_val("t3_no_restart", {31'd0, bsy1}, 32'd0);
    end
    rx1 = 1'b1;
    tick(2);
    check_val("t3_idle", {31'd0, bsy1}, 32'd0);
    send1(8'h5B, 1'b1);
    tick(2);

    // T4: overrun while the consumer stalls
    rdy1 = 1'b0;
    ovr_base = ovr_cnt1;
    send1(8'h5B, 1'b1);
    send1(8'h43, 1'b0);
    check_val("t4_ovr_pulse", {31'd0, ovr1}, 32'd1);
    check_val("t4_hold_frame", {24'd0, frm1}, 32'h5B);
    tick(3);
    check_val("t4_ovr_one_cycle", ovr_cnt1 - ovr_base, 32'd1);
    check_val("t4_still_valid", {31'd0, vld1}, 32'd1);
    check_val("t4_still_5b", {24'd0, frm1}, 32'h5B);
    rdy1 = 1'b1;
    tick(3);
    check_val("t4_drained", {31'd0, vld1}, 32'd0);
    check_val("t4_q_empty", exp_q1.size(), 32'd0);

    // T5: oversampled receiver, glitch rejection then a full frame
    rx4 = 1'b0;
    tick(1);
    check_val("t5_glitch_busy", {31'd0, bsy4}, 32'd1);
    rx4 = 1'b1;
    tick(3);
    check_val("t5_glitch_idle", {31'd0, bsy4}, 32'd0);
    tick(10);
    check_val("t5_no_frame", {31'd0, vld4}, 32'd0);
    send4(8'h5B, 1'b1);
    tick(4);
    send4(8'h59, 1'b1);
    tick(4);
    check_val("t5_q4_empty", exp_q4.size(), 32'd0);

    // T6: reset in the middle of a frame with a pending output
    rdy1 = 1'b0;
    send1(8'h5B, 1'b1);
    rx1 = 1'b0; tick(1);   // start
    rx1 = 1'b1; tick(1);   // d4
    rx1 = 1'b0; tick(1);   // d3
    rx1 = 1'b1; tick(1);   // d2
    rx1 = 1'b0;
    rst_n = 1'b0;
    exp_q1.delete();       // pending frame is lost
    #2;
    check_all_zero1("t6_in_rst");
    tick(2);
    rst_n = 1'b1;
    rdy1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check_val("t6_wait_hi_bsy", {31'd0, bsy1}, 32'd0);
      check_val("t6_wait_hi_vld", {31'd0, vld1}, 32'd0);
    end
    rx1 = 1'b1;
    tick(2);
    send1(8'h5B, 1'b1);
    tick(3);

    check_val("final_q1_empty", exp_q1.size(), 32'd0);
    check_val("final_q4_empty", exp_q4.size(), 32'd0);
    check_val("final_ovr4", ovr_cnt4, 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
